ddr3_pattern_gen: RTL and testbench

Upstream stage of the DDR3 test datapath. Generates 256-bit test words (counter, walking-one, LFSR or constant patterns) and writes them into the DDR input buffer FIFO, whose read side is drained by the DDR3 burst controller. A programmable word count bounds each run, and a free-space threshold on the FIFO write count applies back-pressure so the FIFO never overflows.

---
 rtl/ddr3_pattern_gen.sv | 161 ++++++++++++++++
 tb/tb_ddr3_pattern_gen.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_pattern_gen.sv
// ddr3_pattern_gen
// Produces 256-bit test words (counter, walking-one, LFSR or constant) and
// writes them into the DDR input buffer FIFO. A run starts on a rising edge of
// start and ends after word_total words, or runs forever when word_total is 0.
// Back-pressure comes from fifo_full and a free-space threshold on the write
// count.
//
// Ports:
//   clk, reset     single clock, synchronous active-high reset
//   start          level; rising edge starts a run, low aborts / acknowledges
//   mode           00 counter, 01 walking-one, 10 LFSR, 11 constant
//   seed           initial pattern value (latched at run start)
//   word_total     words per run (latched at run start), 0 = unbounded
//   fifo_wr_count  FIFO write-side occupancy
//   fifo_full      FIFO full flag, hard inhibit
//   fifo_we        registered write strobe, one word per high cycle
//   fifo_data      registered write data, lane k = bits [32k+31:32k]
//   busy / done    high while in RUN / DONE
//   words_sent     words written in the current or last run
//
// FIFO write handshake: a word is transferred on every cycle fifo_we=1; there is
// no ready back from the FIFO, so the block only issues a write when the inputs
// sampled on the previous edge show enough free space.
module ddr3_pattern_gen #(
    parameter int FIFO_DEPTH = 128,
    parameter int HEADROOM   = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [1:0]   mode,
    input  logic [31:0]  seed,
    input  logic [31:0]  word_total,
    input  logic [6:0]   fifo_wr_count,
    input  logic         fifo_full,
    output logic         fifo_we,
    output logic [255:0] fifo_data,
    output logic         busy,
    output logic         done,
    output logic [31:0]  words_sent
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    localparam int          THRESH     = FIFO_DEPTH - HEADROOM;
    localparam logic [31:0] THRESH_W   = THRESH[31:0];
    localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;

    state_t       state;
    logic         start_d;
    logic [1:0]   mode_q;
    logic [31:0]  total_q;
    // Per-word generator state: counter base, one-hot walker, LFSR state
    // before the word, or the constant, depending on mode_q.
    logic [31:0]  gen;
    logic [31:0]  gen_next;
    logic [31:0]  gen_load;
    logic [31:0]  lfsr_s;
    logic [255:0] word;
    logic         space_ok;

    // Compare at 32 bits so the threshold is never truncated to 7 bits.
    assign space_ok = !fifo_full && ({25'd0, fifo_wr_count} < THRESH_W);

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
    endfunction

    always_comb begin
        word     = '0;
        gen_next = gen;
        lfsr_s   = gen;
        case (mode_q)
            2'b00: begin
                for (int k = 0; k < 8; k++) word[32*k +: 32] = gen + 32'(k);
                gen_next = gen + 32'd8;
            end
            2'b01: begin
                for (int k = 0; k < 8; k++) word[32*k +: 32] = gen;
                gen_next = {gen[30:0], gen[31]};
            end
            2'b10: begin
                // Lane k is the state after k+1 steps; lane 7 seeds the next word.
                for (int k = 0; k < 8; k++) begin
                    lfsr_s           = lfsr_step(lfsr_s);
                    word[32*k +: 32] = lfsr_s;
                end
                gen_next = lfsr_s;
            end
            default: begin
                for (int k = 0; k < 8; k++) word[32*k +: 32] = gen;
            end
        endcase
    end

    always_comb begin
        gen_load = seed;
        case (mode)
            2'b01:   gen_load = 32'h1;
            2'b10:   gen_load = (seed == 32'h0) ? 32'h1 : seed;
            default: gen_load = seed;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            start_d    <= 1'b0;
            mode_q     <= 2'b00;
            total_q    <= 32'h0;
            gen        <= 32'h0;
            fifo_we    <= 1'b0;
            fifo_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            words_sent <= 32'h0;
        end else begin
            start_d <= start;
            fifo_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !start_d) begin
                        mode_q     <= mode;
                        total_q    <= word_total;
                        gen        <= gen_load;
                        words_sent <= 32'h0;
                        state      <= RUN;
                        busy       <= 1'b1;
                    end
                end
                RUN: begin
                    if (!start) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (total_q != 32'h0 && words_sent == total_q) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (space_ok) begin
                        fifo_we    <= 1'b1;
                        fifo_data  <= word;
                        gen        <= gen_next;
                        words_sent <= words_sent + 32'd1;
                    end
                end
                DONE: begin
                    if (!start) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_pattern_gen.sv
module tb_ddr3_pattern_gen;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [31:0]  seed = 32'h0;
    logic [31:0]  word_total = 32'h0;
    logic [6:0]   fifo_wr_count = 7'd0;
    logic         fifo_full = 1'b0;
    logic         fifo_we;
    logic [255:0] fifo_data;
    logic         busy;
    logic         done;
    logic [31:0]  words_sent;

    ddr3_pattern_gen #(.FIFO_DEPTH(128), .HEADROOM(4)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed),
        .word_total(word_total), .fifo_wr_count(fifo_wr_count), .fifo_full(fifo_full),
        .fifo_we(fifo_we), .fifo_data(fifo_data), .busy(busy), .done(done),
        .words_sent(words_sent)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_lfsr(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Word w of a run, computed directly from the pattern rules.
    function automatic logic [255:0] ref_word(input logic [1:0] m, input logic [31:0] s, input int w);
        logic [255:0] r;
        logic [31:0]  st;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            case (m)
                2'b00: r[32*k +: 32] = s + 32'(8 * w) + 32'(k);
                2'b01: r[32*k +: 32] = 32'h1 << (w % 32);
                2'b10: begin
                    st = (s == 32'h0) ? 32'h1 : s;
                    for (int i = 0; i < 8 * w + k + 1; i++) st = ref_lfsr(st);
                    r[32*k +: 32] = st;
                end
                default: r[32*k +: 32] = s;
            endcase
        end
        return r;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    logic [1:0]   m_mode;
    logic [31:0]  m_seed;
    int           m_idx = 0;
    int           wr_cnt = 0;
    int           first_cyc = 0;
    int           last_cyc = 0;
    logic [255:0] first_word = '0;
    logic         ok_prev = 1'b1;

    // Free-space condition as seen by the DUT at each edge.
    always @(posedge clk) ok_prev <= !fifo_full && (fifo_wr_count < 7'd124);

    always @(negedge clk) begin
        if (fifo_we === 1'b1) begin
            chk("data", fifo_data, ref_word(m_mode, m_seed, m_idx));
            chk("bp_allowed", {255'd0, ok_prev}, 256'd1);
            if (wr_cnt == 0) begin
                first_cyc  = cyc;
                first_word = fifo_data;
            end
            last_cyc = cyc;
            m_idx++;
            wr_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    int  start_cyc = 0;
    bit  rand_bp = 0;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_bp) begin
                fifo_wr_count = 7'($urandom_range(110, 127));
                fifo_full     = ($urandom_range(0, 7) == 0);
            end
        end
    endtask

    task automatic start_run(input logic [1:0] m, input logic [31:0] s, input logic [31:0] t);
        mode       = m;
        seed       = s;
        word_total = t;
        m_mode     = m;
        m_seed     = s;
        m_idx      = 0;
        wr_cnt     = 0;
        start      = 1'b1;
        start_cyc  = cyc;
    endtask

    task automatic stop_run();
        start = 1'b0;
        tick(2);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        chk("done_within_budget", {255'd0, done}, 256'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int q;
        logic [1:0]  rm;
        logic [31:0] rt;

        // Reset state
        tick(3);
        chk("rst_we", {255'd0, fifo_we}, 256'd0);
        chk("rst_data", fifo_data, 256'd0);
        chk("rst_busy", {255'd0, busy}, 256'd0);
        chk("rst_done", {255'd0, done}, 256'd0);
        chk("rst_ws", {224'd0, words_sent}, 256'd0);
        reset = 1'b0;
        tick(2);

        // Counter run, 3 words
        start_run(2'b00, 32'h1000, 32'd3);
        wait_done(50);
        chk("cnt_writes", 256'(wr_cnt), 256'd3);
        chk("cnt_latency", 256'(first_cyc - start_cyc), 256'd2);
        chk("cnt_back_to_back", 256'(last_cyc - first_cyc), 256'd2);
        chk("cnt_ws", {224'd0, words_sent}, 256'd3);
        chk("cnt_busy_in_done", {255'd0, busy}, 256'd0);
        stop_run();
        chk("cnt_idle_done", {255'd0, done}, 256'd0);
        chk("cnt_idle_ws_held", {224'd0, words_sent}, 256'd3);

        // Back-pressure from the write count
        fifo_wr_count = 7'd124;
        start_run(2'b00, $urandom, 32'd5);
        tick(20);
        chk("bp_no_writes", 256'(wr_cnt), 256'd0);
        chk("bp_busy", {255'd0, busy}, 256'd1);
        fifo_wr_count = 7'd100;
        q = cyc;
        wait_done(50);
        chk("bp_resume", 256'(first_cyc - q), 256'd1);
        chk("bp_writes", 256'(wr_cnt), 256'd5);
        stop_run();

        // Back-pressure from fifo_full, then release at the threshold boundary
        fifo_full     = 1'b1;
        fifo_wr_count = 7'd0;
        start_run(2'b11, $urandom, 32'd4);
        tick(10);
        chk("full_no_writes", 256'(wr_cnt), 256'd0);
        fifo_full     = 1'b0;
        fifo_wr_count = 7'd123;
        q = cyc;
        wait_done(50);
        chk("full_resume", 256'(first_cyc - q), 256'd1);
        chk("full_writes", 256'(wr_cnt), 256'd4);
        fifo_wr_count = 7'd0;
        stop_run();

        // LFSR with zero seed
        start_run(2'b10, 32'h0, 32'd2);
        wait_done(50);
        chk("lfsr_lane0", {224'd0, first_word[31:0]}, 256'h8020_0003);
        chk("lfsr_writes", 256'(wr_cnt), 256'd2);
        stop_run();

        // Walking-one wrap
        start_run(2'b01, $urandom, 32'd33);
        wait_done(100);
        chk("walk_writes", 256'(wr_cnt), 256'd33);
        chk("walk_ws", {224'd0, words_sent}, 256'd33);
        stop_run();

        // Randomized runs under random back-pressure
        for (int r = 0; r < 6; r++) begin
            rm = 2'($urandom_range(0, 3));
            rt = 32'($urandom_range(1, 20));
            start_run(rm, $urandom, rt);
            rand_bp = 1;
            wait_done(600);
            rand_bp = 0;
            fifo_wr_count = 7'd0;
            fifo_full     = 1'b0;
            chk("rand_writes", 256'(wr_cnt), {224'd0, rt});
            chk("rand_ws", {224'd0, words_sent}, {224'd0, rt});
            stop_run();
        end

        // Abort an unbounded run after 10 words
        start_run(2'($urandom_range(0, 3)), $urandom, 32'd0);
        q = 0;
        while (words_sent != 32'd10 && q < 200) begin
            tick(1);
            q++;
        end
        start = 1'b0;
        tick(3);
        chk("abort_writes", 256'(wr_cnt), 256'd10);
        chk("abort_ws", {224'd0, words_sent}, 256'd10);
        chk("abort_busy", {255'd0, busy}, 256'd0);
        chk("abort_done", {255'd0, done}, 256'd0);

        // Restart, then reset mid-run
        start_run(2'b00, $urandom, 32'd0);
        tick(6);
        reset = 1'b1;
        start = 1'b0;
        tick(1);
        chk("midrst_we", {255'd0, fifo_we}, 256'd0);
        chk("midrst_data", fifo_data, 256'd0);
        chk("midrst_busy", {255'd0, busy}, 256'd0);
        chk("midrst_ws", {224'd0, words_sent}, 256'd0);
        reset = 1'b0;
        q = wr_cnt;
        tick(5);
        chk("midrst_no_writes", 256'(wr_cnt), 256'(q));

        // Re-arm: holding start after done gives no new run
        start_run(2'b00, 32'h55, 32'd2);
        wait_done(50);
        tick(10);
        chk("rearm_hold_writes", 256'(wr_cnt), 256'd2);
        chk("rearm_hold_done", {255'd0, done}, 256'd1);
        start = 1'b0;
        tick(1);
        start_run(2'b00, 32'h900, 32'd2);
        tick(1);
        chk("rearm_busy", {255'd0, busy}, 256'd1);
        chk("rearm_ws_cleared", {224'd0, words_sent}, 256'd0);
        wait_done(50);
        chk("rearm_writes", 256'(wr_cnt), 256'd2);
        chk("rearm_ws", {224'd0, words_sent}, 256'd2);
        stop_run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
